pio_key_debounce: RTL and testbench

PIO_KEY_DEBOUNCE -- requirements
Module: pio_key_debounce

---
 rtl/pio_key_debounce.sv | 143 ++++++++++++++
 tb/tb_pio_key_debounce.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_key_debounce.sv
// pio_key_debounce: Avalon-MM key PIO with per-bit debounce,
// sticky edge capture and a masked level interrupt.
module pio_key_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 0) ?
    $clog2(DEBOUNCE_CYCLES + 1) : 1;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_RAW  = 2'd1;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_EDGE = 2'd3;

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] raw_q;
  logic [WIDTH-1:0] deb_q;
  logic [WIDTH-1:0] deb_d_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] deb_nxt;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] edge_nxt;
  logic [WIDTH-1:0] rd_sel;
  logic             wr;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      raw_q  <= '0;
    end else begin
      sync_q <= in_port;
      raw_q  <= sync_q;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign deb_nxt = raw_q;
    end else begin : g_count
      localparam logic [CW-1:0] LIMIT =
        CW'(DEBOUNCE_CYCLES);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_nxt;
        logic          flip;

        // Count only while raw disagrees; the count
        // never passes LIMIT, so it cannot wrap.
        always_comb begin
          flip    = 1'b0;
          cnt_nxt = '0;
          if (raw_q[i] != deb_q[i]) begin
            if (cnt_q + CW'(1) == LIMIT) begin
              flip = 1'b1;
            end else begin
              cnt_nxt = cnt_q + CW'(1);
            end
          end
        end

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_nxt;
          end
        end

        assign deb_nxt[i] = deb_q[i] ^ flip;
      end
    end
  endgenerate

  always_comb begin
    det = '0;
    if (EDGE_TYPE == 0) begin
      det = deb_q & ~deb_d_q;
    end else if (EDGE_TYPE == 1) begin
      det = ~deb_q & deb_d_q;
    end else begin
      det = deb_q ^ deb_d_q;
    end
  end

  // A fresh edge on the clearing cycle keeps its bit set.
  always_comb begin
    clr = '0;
    if (wr && address == A_EDGE) begin
      clr = writedata[WIDTH-1:0];
    end
    edge_nxt = (edge_q & ~clr) | det;
  end

  always_comb begin
    rd_sel = '0;
    unique case (address)
      A_DATA: rd_sel = deb_q;
      A_RAW:  rd_sel = raw_q;
      A_MASK: rd_sel = mask_q;
      A_EDGE: rd_sel = edge_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_q    <= '0;
      deb_d_q  <= '0;
      mask_q   <= '0;
      edge_q   <= '0;
      readdata <= '0;
    end else begin
      deb_q   <= deb_nxt;
      deb_d_q <= deb_q;
      if (wr && address == A_MASK) begin
        mask_q <= writedata[WIDTH-1:0];
      end
      edge_q   <= edge_nxt;
      readdata <= 32'(rd_sel);
    end
  end

  assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_pio_key_debounce.sv
// tb_pio_key_debounce: directed and randomized checks of four
// key PIO variants against a history-window reference model.
`timescale 1ns/1ps
module tb_pio_key_debounce;

  localparam int W  = 4;
  localparam int DB = 4;
  localparam int HN = 8192;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [W-1:0] in_port;
  logic [31:0]  rd [4];
  logic         irq [4];

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  // 0: any edge, 1: rising, 2: falling, 3: bypass (any edge)
  pio_key_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(rd[0]), .irq(irq[0]));
  pio_key_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(rd[1]), .irq(irq[1]));
  pio_key_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(DB), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(rd[2]), .irq(irq[2]));
  pio_key_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u_byp (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(rd[3]), .irq(irq[3]));

  // Model: histories indexed by edge number since reset release.
  logic [W-1:0] inp_h [HN];
  logic [W-1:0] deb_h [HN];
  logic [W-1:0] byp_h [HN];
  int           n;
  logic [W-1:0] m_mask;
  logic [W-1:0] m_ec [4];
  logic [31:0]  m_rd [4];
  logic         m_irq [4];

  function automatic logic [W-1:0] raw_at(int i);
    if (i < 1) return '0;
    return inp_h[i-1];
  endfunction

  function automatic logic [W-1:0] deb_at(int i);
    if (i < 0) return '0;
    return deb_h[i];
  endfunction

  function automatic logic [W-1:0] byp_at(int i);
    if (i < 0) return '0;
    return byp_h[i];
  endfunction

  function automatic int et_of(int i);
    if (i == 1) return 0;
    if (i == 2) return 1;
    return 2;
  endfunction

  function automatic logic [W-1:0] det(logic [W-1:0] cur, logic [W-1:0] prev, int et);
    if (et == 0) return cur & ~prev;
    if (et == 1) return ~cur & prev;
    return cur ^ prev;
  endfunction

  task automatic model_reset();
    n = 0;
    m_mask = '0;
    for (int i = 0; i < 4; i++) begin
      m_ec[i] = '0;
      m_rd[i] = '0;
      m_irq[i] = 1'b0;
    end
  endtask

  // A debounced bit flips when the previous DB raw samples all
  // disagreed with it and it held steady over that window.
  task automatic model_step();
    logic [W-1:0] nd, rj, dj, clr, dv, pv, sel;
    bit ok;
    inp_h[n] = in_port;
    nd = deb_at(n - 1);
    for (int b = 0; b < W; b++) begin
      ok = 1'b1;
      for (int j = 1; j <= DB; j++) begin
        rj = raw_at(n - j);
        dj = deb_at(n - j);
        if (rj[b] == nd[b] || dj[b] != nd[b]) ok = 1'b0;
      end
      if (ok) nd[b] = ~nd[b];
    end
    deb_h[n] = nd;
    byp_h[n] = raw_at(n - 1);
    clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
    for (int i = 0; i < 4; i++) begin
      dv = (i == 3) ? byp_at(n - 1) : deb_at(n - 1);
      pv = (i == 3) ? byp_at(n - 2) : deb_at(n - 2);
      case (address)
        2'd0: sel = dv;
        2'd1: sel = raw_at(n - 1);
        2'd2: sel = m_mask;
        default: sel = m_ec[i];
      endcase
      m_rd[i] = 32'(sel);
      m_ec[i] = (m_ec[i] & ~clr) | det(dv, pv, et_of(i));
    end
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
    for (int i = 0; i < 4; i++) m_irq[i] = |(m_ec[i] & m_mask);
    n++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    chipselect = 1'b0;
    write_n = 1'b1;
    address = 2'd0;
    writedata = '0;
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n = 1'b0;
    address = a;
    writedata = d;
    tick();
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic test_reset();
    in_port = 4'hF;
    reset_n = 1'b0;
    model_reset();
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      tick();
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (rd[i] !== 32'h0 || irq[i] !== 1'b0) begin
          n_errs++;
          $display("FAIL reset_hold inst%0d: rd=%h irq=%b expected 0/0", i, rd[i], irq[i]);
        end
      end
    end
    reset_n = 1'b1;
    address = 2'd0;
    for (int j = 1; j <= 7; j++) begin
      tick();
      n_checks++;
      if (rd[0] !== ((j >= 7) ? 32'hF : 32'h0)) begin
        n_errs++;
        $display("FAIL held_release edge%0d: rd=%h expected %h", j, rd[0], (j >= 7) ? 32'hF : 32'h0);
      end
      n_checks++;
      if (rd[3] !== ((j >= 4) ? 32'hF : 32'h0)) begin
        n_errs++;
        $display("FAIL held_release_byp edge%0d: rd=%h expected %h", j, rd[3], (j >= 4) ? 32'hF : 32'h0);
      end
    end
  endtask

  task automatic test_latency();
    in_port = 4'h0;
    do_reset();
    for (int j = 0; j < 10; j++) tick();
    in_port = 4'h1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      n_checks++;
      if (rd[0] !== ((j >= 7) ? 32'h1 : 32'h0)) begin
        n_errs++;
        $display("FAIL latency edge+%0d: rd=%h expected %h", j, rd[0], (j >= 7) ? 32'h1 : 32'h0);
      end
      n_checks++;
      if (rd[3] !== ((j >= 4) ? 32'h1 : 32'h0)) begin
        n_errs++;
        $display("FAIL latency_byp edge+%0d: rd=%h expected %h", j, rd[3], (j >= 4) ? 32'h1 : 32'h0);
      end
      n_checks++;
      if (rd[1] !== m_rd[1]) begin
        n_errs++;
        $display("FAIL latency_model edge+%0d: rd=%h expected %h", j, rd[1], m_rd[1]);
      end
    end
    address = 2'd3;
    tick();
    n_checks++;
    if (rd[0] !== 32'h1 || irq[0] !== 1'b0) begin
      n_errs++;
      $display("FAIL latency_edge: rd=%h irq=%b expected 1/0", rd[0], irq[0]);
    end
  endtask

  task automatic test_glitch();
    logic seen;
    in_port = 4'h0;
    do_reset();
    tick();
    seen = 1'b0;
    in_port = 4'h2;
    for (int j = 0; j < 3; j++) tick();
    in_port = 4'h0;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (rd[0][1] !== 1'b0 || irq[0] !== 1'b0) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_errs++;
      $display("FAIL glitch3_data: bit1 or irq went high, expected steady 0");
    end
    in_port = 4'h8;
    for (int j = 0; j < 4; j++) tick();
    in_port = 4'h0;
    for (int j = 0; j < 14; j++) tick();
    address = 2'd3;
    tick();
    n_checks++;
    if (rd[0] !== 32'h8) begin
      n_errs++;
      $display("FAIL glitch4_edge: rd=%h expected 00000008", rd[0]);
    end
  endtask

  task automatic test_irq();
    in_port = 4'h0;
    do_reset();
    bus_write(2'd2, 32'hFFFF_FFF1);
    address = 2'd2;
    tick();
    n_checks++;
    if (rd[0] !== 32'h1) begin
      n_errs++;
      $display("FAIL mask_read: rd=%h expected 00000001", rd[0]);
    end
    bus_write(2'd0, 32'hF);
    bus_write(2'd1, 32'hF);
    address = 2'd2;
    tick();
    n_checks++;
    if (rd[0] !== 32'h1) begin
      n_errs++;
      $display("FAIL ro_write: mask rd=%h expected 00000001", rd[0]);
    end
    in_port = 4'h1;
    for (int j = 0; j < 10; j++) tick();
    n_checks++;
    if (irq[0] !== 1'b1 || irq[2] !== 1'b0) begin
      n_errs++;
      $display("FAIL irq_set: any=%b fall=%b expected 1/0", irq[0], irq[2]);
    end
    bus_write(2'd3, 32'h0);
    n_checks++;
    if (irq[0] !== 1'b1) begin
      n_errs++;
      $display("FAIL clear_zero: irq=%b expected 1", irq[0]);
    end
    bus_write(2'd3, 32'h1);
    n_checks++;
    if (irq[0] !== 1'b0 || irq[1] !== 1'b0) begin
      n_errs++;
      $display("FAIL clear_one: any=%b rise=%b expected 0/0", irq[0], irq[1]);
    end
  endtask

  task automatic test_collision();
    in_port = 4'h0;
    do_reset();
    bus_write(2'd2, 32'h1);
    in_port = 4'h1;
    for (int j = 0; j < 10; j++) tick();
    bus_write(2'd3, 32'h1);
    in_port = 4'h0;
    for (int j = 0; j < 6; j++) tick();
    n_checks++;
    if (irq[0] !== 1'b0) begin
      n_errs++;
      $display("FAIL collide_pre: irq=%b expected 0", irq[0]);
    end
    bus_write(2'd3, 32'h1);
    n_checks++;
    if (irq[0] !== 1'b1) begin
      n_errs++;
      $display("FAIL collide_irq: irq=%b expected 1", irq[0]);
    end
    address = 2'd3;
    tick();
    n_checks++;
    if (rd[0] !== 32'h1) begin
      n_errs++;
      $display("FAIL collide_edge: rd=%h expected 00000001", rd[0]);
    end
  endtask

  task automatic test_edge_type();
    in_port = 4'h0;
    do_reset();
    in_port = 4'h4;
    for (int j = 0; j < 10; j++) tick();
    address = 2'd3;
    tick();
    n_checks++;
    if (rd[1] !== 32'h4 || rd[2] !== 32'h0 || rd[0] !== 32'h4) begin
      n_errs++;
      $display("FAIL edge_press: rise=%h fall=%h any=%h expected 4/0/4", rd[1], rd[2], rd[0]);
    end
    bus_write(2'd3, 32'hF);
    in_port = 4'h0;
    for (int j = 0; j < 10; j++) tick();
    address = 2'd3;
    tick();
    n_checks++;
    if (rd[1] !== 32'h0 || rd[2] !== 32'h4 || rd[0] !== 32'h4) begin
      n_errs++;
      $display("FAIL edge_release: rise=%h fall=%h any=%h expected 0/4/4", rd[1], rd[2], rd[0]);
    end
  endtask

  task automatic test_reset_mid();
    in_port = 4'h0;
    do_reset();
    address = 2'd1;
    for (int j = 0; j < 3; j++) tick();
    in_port = 4'h1;
    for (int j = 0; j < 4; j++) tick();
    n_checks++;
    if (rd[0] !== 32'h1) begin
      n_errs++;
      $display("FAIL mid_raw: rd=%h expected 00000001", rd[0]);
    end
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rd[i] !== 32'h0 || irq[i] !== 1'b0) begin
        n_errs++;
        $display("FAIL mid_reset inst%0d: rd=%h irq=%b expected 0/0", i, rd[i], irq[i]);
      end
    end
    tick();
    reset_n = 1'b1;
    address = 2'd0;
    for (int j = 1; j <= 7; j++) begin
      tick();
      n_checks++;
      if (rd[0] !== ((j >= 7) ? 32'h1 : 32'h0)) begin
        n_errs++;
        $display("FAIL mid_restart edge%0d: rd=%h expected %h", j, rd[0], (j >= 7) ? 32'h1 : 32'h0);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] fl;
    in_port = 4'h0;
    do_reset();
    for (int c = 0; c < 900; c++) begin
      for (int b = 0; b < W; b++) fl[b] = ($urandom_range(7) == 0);
      in_port = in_port ^ fl;
      address = 2'($urandom_range(3));
      chipselect = ($urandom_range(3) != 0);
      write_n = ($urandom_range(5) != 0);
      writedata = $urandom;
      reset_n = !(c >= 450 && c < 452);
      if (!reset_n) model_reset();
      tick();
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (rd[i] !== m_rd[i] || irq[i] !== m_irq[i]) begin
          n_errs++;
          $display("FAIL random c%0d inst%0d: rd=%h irq=%b expected %h/%b", c, i, rd[i], irq[i], m_rd[i], m_irq[i]);
        end
      end
    end
    reset_n = 1'b1;
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    address = 2'd0;
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = '0;
    in_port = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_latency();
    test_glitch();
    test_irq();
    test_collision();
    test_edge_type();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
